// File: rtl/rgb_window_3x3.sv
// 3x3 RGB neighbourhood window generator: two line buffers plus column shift registers per row.
// Optional centre-coordinate outputs (out_x/out_y) are enabled by defining WIN_CENTER_COORD_EN.
module rgb_window_3x3 #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic [DW-1:0]            in_r,
    input  logic [DW-1:0]            in_g,
    input  logic [DW-1:0]            in_b,
    output logic                     out_valid,
    output logic [9*DW-1:0]          win_r,
    output logic [9*DW-1:0]          win_g,
    output logic [9*DW-1:0]          win_b,
`ifdef WIN_CENTER_COORD_EN
    output logic [$clog2(IMG_W)-1:0] out_x,
    output logic [$clog2(IMG_H)-1:0] out_y,
`endif
    output logic                     frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int PW = 3 * DW;

    logic [CW-1:0] col, px_col_p0;
    logic [RW-1:0] row, px_row_p0;
    logic [PW-1:0] lb0 [IMG_W];
    logic [PW-1:0] lb1 [IMG_W];
    logic [PW-1:0] top_rd_p0, mid_rd_p0, bot_px_p0;
    logic [PW-1:0] top_sr [2];
    logic [PW-1:0] mid_sr [2];
    logic [PW-1:0] bot_sr [2];
    logic          win_en_p0, last_px_p0;
    logic          vld_p1, fd_p1;

    // Pixels are stored as {r,g,b}; ch 2 = red, 1 = green, 0 = blue.
    function automatic logic [9*DW-1:0] pack_win(
        input int            ch,
        input logic [PW-1:0] a, input logic [PW-1:0] b, input logic [PW-1:0] c,
        input logic [PW-1:0] d, input logic [PW-1:0] e, input logic [PW-1:0] f,
        input logic [PW-1:0] g, input logic [PW-1:0] h, input logic [PW-1:0] i
    );
        return {i[ch*DW +: DW], h[ch*DW +: DW], g[ch*DW +: DW],
                f[ch*DW +: DW], e[ch*DW +: DW], d[ch*DW +: DW],
                c[ch*DW +: DW], b[ch*DW +: DW], a[ch*DW +: DW]};
    endfunction

    // Stage p0: position of the accepted pixel and line-buffer reads
    assign px_col_p0  = in_sof ? '0 : col;
    assign px_row_p0  = in_sof ? '0 : row;
    assign top_rd_p0  = lb1[px_col_p0];
    assign mid_rd_p0  = lb0[px_col_p0];
    assign bot_px_p0  = {in_r, in_g, in_b};
    assign win_en_p0  = in_valid && (px_col_p0 >= CW'(2)) && (px_row_p0 >= RW'(2));
    assign last_px_p0 = (px_col_p0 == CW'(IMG_W - 1)) && (px_row_p0 == RW'(IMG_H - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col    <= '0;
            row    <= '0;
            vld_p1 <= 1'b0;
            fd_p1  <= 1'b0;
        end else begin
            vld_p1 <= win_en_p0;
            fd_p1  <= in_valid && last_px_p0;
            if (in_valid) begin
                if (px_col_p0 == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (px_row_p0 == RW'(IMG_H - 1)) ? '0 : px_row_p0 + RW'(1);
                end else begin
                    col <= px_col_p0 + CW'(1);
                    row <= px_row_p0;
                end
            end
        end
    end

    // Read-before-write: lb1 takes the row lb0 held, lb0 takes the new pixel.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb1[px_col_p0] <= mid_rd_p0;
            lb0[px_col_p0] <= bot_px_p0;
        end
    end

    // Stage p1: column shift registers and registered window outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                top_sr[k] <= '0;
                mid_sr[k] <= '0;
                bot_sr[k] <= '0;
            end
            win_r <= '0;
            win_g <= '0;
            win_b <= '0;
`ifdef WIN_CENTER_COORD_EN
            out_x <= '0;
            out_y <= '0;
`endif
        end else if (in_valid) begin
            top_sr[0] <= top_sr[1];
            top_sr[1] <= top_rd_p0;
            mid_sr[0] <= mid_sr[1];
            mid_sr[1] <= mid_rd_p0;
            bot_sr[0] <= bot_sr[1];
            bot_sr[1] <= bot_px_p0;
            if (win_en_p0) begin
                win_r <= pack_win(2, top_sr[0], top_sr[1], top_rd_p0,
                                  mid_sr[0], mid_sr[1], mid_rd_p0,
                                  bot_sr[0], bot_sr[1], bot_px_p0);
                win_g <= pack_win(1, top_sr[0], top_sr[1], top_rd_p0,
                                  mid_sr[0], mid_sr[1], mid_rd_p0,
                                  bot_sr[0], bot_sr[1], bot_px_p0);
                win_b <= pack_win(0, top_sr[0], top_sr[1], top_rd_p0,
                                  mid_sr[0], mid_sr[1], mid_rd_p0,
                                  bot_sr[0], bot_sr[1], bot_px_p0);
`ifdef WIN_CENTER_COORD_EN
                out_x <= px_col_p0 - CW'(1);
                out_y <= px_row_p0 - RW'(1);
`endif
            end
        end
    end

    assign out_valid  = vld_p1;
    assign frame_done = fd_p1;

endmodule

// File: tb/tb_rgb_window_3x3.sv
// Randomized self-checking bench for rgb_window_3x3 against a frame-array window model.
module tb_rgb_window_3x3;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_sof = 1'b0;
    logic [DW-1:0]   in_r = '0, in_g = '0, in_b = '0;
    logic            out_valid, frame_done;
    logic [9*DW-1:0] win_r, win_g, win_b;
`ifdef WIN_CENTER_COORD_EN
    logic [$clog2(W)-1:0] out_x;
    logic [$clog2(H)-1:0] out_y;
`endif

    rgb_window_3x3 #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .out_valid(out_valid), .win_r(win_r), .win_g(win_g), .win_b(win_b),
`ifdef WIN_CENTER_COORD_EN
        .out_x(out_x), .out_y(out_y),
`endif
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: image stored by (row, col); window read straight from it.
    logic [23:0]     img [H][W];
    int              mx = 0, my = 0;
    logic            exp_valid = 1'b0, exp_fd = 1'b0;
    logic [9*DW-1:0] exp_wr = '0, exp_wg = '0, exp_wb = '0;

    task automatic model_reset();
        mx = 0; my = 0;
        exp_valid = 1'b0; exp_fd = 1'b0;
        exp_wr = '0; exp_wg = '0; exp_wb = '0;
    endtask

    task automatic apply(input bit v, input bit sof, input logic [7:0] r, g, b);
        logic [23:0] pix;
        in_valid = v; in_sof = sof; in_r = r; in_g = g; in_b = b;
        exp_valid = 1'b0;
        exp_fd    = 1'b0;
        if (v) begin
            if (sof) begin mx = 0; my = 0; end
            img[my][mx] = {r, g, b};
            if (mx >= 2 && my >= 2) begin
                exp_valid = 1'b1;
                for (int k = 0; k < 9; k++) begin
                    pix = img[my - 2 + k / 3][mx - 2 + k % 3];
                    exp_wr[k*8 +: 8] = pix[23:16];
                    exp_wg[k*8 +: 8] = pix[15:8];
                    exp_wb[k*8 +: 8] = pix[7:0];
                end
            end
            exp_fd = (mx == W - 1) && (my == H - 1);
            mx++;
            if (mx == W) begin
                mx = 0;
                my = (my == H - 1) ? 0 : my + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        nvec++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
            nerr++;
            $display("FAIL reset_ctrl: out_valid=%b frame_done=%b, want 0 0", out_valid, frame_done);
        end
        nvec++;
        if ({win_r, win_g, win_b} !== '0) begin
            nerr++;
            $display("FAIL reset_win: got %h %h %h, want all zero", win_r, win_g, win_b);
        end
        #3 rst = 1'b0;
    endtask

    task automatic test_frame_pattern();
        int nwin = 0;
        logic [7:0] r;
`ifdef WIN_CENTER_COORD_EN
        int xs [6] = '{1, 2, 3, 1, 2, 3};
        int ys [6] = '{1, 1, 1, 2, 2, 2};
`endif
        for (int p = 0; p < W * H; p++) begin
            r = 8'(16 * (p / W) + p % W);
            apply(1, 0, r, r + 8'd1, r + 8'd2);
            nvec++;
            if (out_valid !== exp_valid || frame_done !== exp_fd) begin
                nerr++;
                $display("FAIL pattern_ctrl p=%0d: valid/done=%b%b, want %b%b", p, out_valid, frame_done, exp_valid, exp_fd);
            end
            nvec++;
            if ({win_r, win_g, win_b} !== {exp_wr, exp_wg, exp_wb}) begin
                nerr++;
                $display("FAIL pattern_win p=%0d: got %h/%h/%h, want %h/%h/%h", p, win_r, win_g, win_b, exp_wr, exp_wg, exp_wb);
            end
            if (out_valid === 1'b1 && nwin == 0) begin
                nvec++;
                if (p != 12 || win_r !== 72'h22_21_20_12_11_10_02_01_00) begin
                    nerr++;
                    $display("FAIL first_window: p=%0d win_r=%h, want p=12 win_r=222120121110020100", p, win_r);
                end
            end
            if (frame_done === 1'b1) begin
                nvec++;
                if (win_r[4*8 +: 8] !== 8'h23) begin
                    nerr++;
                    $display("FAIL last_centre: e_r=%h, want 23", win_r[4*8 +: 8]);
                end
            end
`ifdef WIN_CENTER_COORD_EN
            if (out_valid === 1'b1 && nwin < 6) begin
                nvec++;
                if (int'(out_x) != xs[nwin] || int'(out_y) != ys[nwin]) begin
                    nerr++;
                    $display("FAIL coord %0d: (%0d,%0d), want (%0d,%0d)", nwin, out_x, out_y, xs[nwin], ys[nwin]);
                end
            end
`endif
            if (out_valid === 1'b1) nwin++;
        end
        nvec++;
        if (nwin != 6) begin
            nerr++;
            $display("FAIL pattern_count: %0d windows, want 6", nwin);
        end
    endtask

    task automatic test_gapped();
        int nwin = 0;
        for (int c = 0; c < 2 * W * H; c++) begin
            apply(c % 2 == 0, 0, 8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)));
            nvec++;
            if (out_valid !== exp_valid || frame_done !== exp_fd) begin
                nerr++;
                $display("FAIL gapped_ctrl c=%0d: valid/done=%b%b, want %b%b", c, out_valid, frame_done, exp_valid, exp_fd);
            end
            nvec++;
            if ({win_r, win_g, win_b} !== {exp_wr, exp_wg, exp_wb}) begin
                nerr++;
                $display("FAIL gapped_win c=%0d: got %h/%h/%h, want %h/%h/%h", c, win_r, win_g, win_b, exp_wr, exp_wg, exp_wb);
            end
            if (out_valid === 1'b1) nwin++;
        end
        nvec++;
        if (nwin != 6) begin
            nerr++;
            $display("FAIL gapped_count: %0d windows, want 6", nwin);
        end
    endtask

    task automatic test_back_to_back();
        int nwin = 0;
        for (int c = 0; c < 2 * W * H; c++) begin
            apply(1, c == W * H, 8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)));
            nvec++;
            if (out_valid !== exp_valid || frame_done !== exp_fd) begin
                nerr++;
                $display("FAIL b2b_ctrl c=%0d: valid/done=%b%b, want %b%b", c, out_valid, frame_done, exp_valid, exp_fd);
            end
            nvec++;
            if ({win_r, win_g, win_b} !== {exp_wr, exp_wg, exp_wb}) begin
                nerr++;
                $display("FAIL b2b_win c=%0d: got %h/%h/%h, want %h/%h/%h", c, win_r, win_g, win_b, exp_wr, exp_wg, exp_wb);
            end
            if (out_valid === 1'b1) nwin++;
        end
        nvec++;
        if (nwin != 12) begin
            nerr++;
            $display("FAIL b2b_count: %0d windows, want 12", nwin);
        end
    endtask

    task automatic test_mid_sof();
        int nwin = 0;
        // 13 pixels reach (2,2); pixel 13 would be (3,2) but carries in_sof.
        for (int c = 0; c < 13 + W * H; c++) begin
            apply(1, c == 13, 8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)));
            nvec++;
            if (out_valid !== exp_valid || frame_done !== exp_fd) begin
                nerr++;
                $display("FAIL midsof_ctrl c=%0d: valid/done=%b%b, want %b%b", c, out_valid, frame_done, exp_valid, exp_fd);
            end
            nvec++;
            if ({win_r, win_g, win_b} !== {exp_wr, exp_wg, exp_wb}) begin
                nerr++;
                $display("FAIL midsof_win c=%0d: got %h/%h/%h, want %h/%h/%h", c, win_r, win_g, win_b, exp_wr, exp_wg, exp_wb);
            end
            if (out_valid === 1'b1) nwin++;
        end
        nvec++;
        if (nwin != 7) begin
            nerr++;
            $display("FAIL midsof_count: %0d windows, want 7", nwin);
        end
    endtask

    task automatic test_async_reset();
        int nwin = 0;
        for (int c = 0; c < 14; c++)
            apply(1, 0, 8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)));
        nvec++;
        if (out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL pre_reset_valid: out_valid=%b, want 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        nvec++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || {win_r, win_g, win_b} !== '0) begin
            nerr++;
            $display("FAIL async_reset: valid=%b done=%b win=%h/%h/%h, want 0 0 zero", out_valid, frame_done, win_r, win_g, win_b);
        end
        apply(0, 0, 8'd0, 8'd0, 8'd0);
        apply(0, 0, 8'd0, 8'd0, 8'd0);
        #3 rst = 1'b0;
        for (int c = 0; c < W * H; c++) begin
            apply(1, 0, 8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)));
            nvec++;
            if (out_valid !== exp_valid || frame_done !== exp_fd) begin
                nerr++;
                $display("FAIL postrst_ctrl c=%0d: valid/done=%b%b, want %b%b", c, out_valid, frame_done, exp_valid, exp_fd);
            end
            nvec++;
            if ({win_r, win_g, win_b} !== {exp_wr, exp_wg, exp_wb}) begin
                nerr++;
                $display("FAIL postrst_win c=%0d: got %h/%h/%h, want %h/%h/%h", c, win_r, win_g, win_b, exp_wr, exp_wg, exp_wb);
            end
            if (out_valid === 1'b1) nwin++;
        end
        nvec++;
        if (nwin != 6) begin
            nerr++;
            $display("FAIL postrst_count: %0d windows, want 6", nwin);
        end
    endtask

    initial begin
        test_reset();
        test_frame_pattern();
        test_gapped();
        test_back_to_back();
        test_mid_sof();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
